// File: rtl/riscv_soft_fetch.sv
// rtl/riscv_soft_fetch.sv - instruction fetch stage: PC, icache request/response, instruction FIFO
//
// Purpose:
//   Issues sequential word fetches to the instruction cache, collects the
//   in-order responses into a DEPTH-entry FIFO of {inst, pc}, and hands them
//   to execute over a valid/ready handshake. A redirect from execute moves
//   the fetch PC, flushes the FIFO and marks every in-flight response to be
//   discarded on arrival.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_cache_req_*         request handshake (valid/ready, word address)
//   i_cache_resp_*        in-order responses, no backpressure
//   redirect_valid/pc     new fetch target from execute
//   inst_valid/ready      FIFO head handshake toward execute
//   inst_data/pc          FIFO head contents (zero while empty)
module riscv_soft_fetch #(
  parameter int                 XPR_LEN  = 32,
  parameter logic [XPR_LEN-1:0] RESET_PC = 32'h0000_0200,
  parameter int                 DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cache_req_ready,
  output logic               i_cache_req_valid,
  output logic [XPR_LEN-1:0] i_cache_req_addr,
  input  logic               i_cache_resp_valid,
  input  logic [31:0]        i_cache_resp_data,
  input  logic               redirect_valid,
  input  logic [XPR_LEN-1:0] redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_data,
  output logic [XPR_LEN-1:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);

  logic [XPR_LEN-1:0] fetch_pc;
  logic [XPR_LEN-1:0] resp_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  logic [31:0]        inst_mem [DEPTH];
  logic [XPR_LEN-1:0] pc_mem   [DEPTH];

  logic               req_fire;
  logic               push;
  logic               pop;
  logic [CW:0]        credit_used;
  logic [XPR_LEN-1:0] target_pc;
  logic               unused_pc_bits;

  assign target_pc      = {redirect_pc[XPR_LEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // A request is only offered when its response is guaranteed a FIFO slot:
  // in-flight plus buffered entries never exceed DEPTH.
  assign credit_used       = {1'b0, outstanding} + {1'b0, count};
  assign i_cache_req_valid = !reset && !redirect_valid && (credit_used < {1'b0, DEPTH_N});
  assign i_cache_req_addr  = fetch_pc;
  assign req_fire          = i_cache_req_valid && i_cache_req_ready;

  // Responses owed to a pre-redirect request (drop_cnt) or arriving in the
  // redirect cycle itself never enter the FIFO.
  assign push = i_cache_resp_valid && !redirect_valid && (drop_cnt == '0);
  assign pop  = inst_valid && inst_ready;

  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? inst_mem[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      // Every request still unanswered after this cycle is stale. Dropped
      // responses are still counted in outstanding, so this subsumes the
      // old drop_cnt.
      outstanding <= outstanding - CW'(i_cache_resp_valid);
      drop_cnt    <= outstanding - CW'(i_cache_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XPR_LEN'(4);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(i_cache_resp_valid);
      if (i_cache_resp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + XPR_LEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= i_cache_resp_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push |-> (count != DEPTH_N));

endmodule

// File: tb/tb_riscv_soft_fetch.sv
// tb/tb_riscv_soft_fetch.sv - directed self-checking bench for riscv_soft_fetch
module tb_riscv_soft_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_cache_req_ready;
  logic        i_cache_req_valid;
  logic [31:0] i_cache_req_addr;
  logic        i_cache_resp_valid;
  logic [31:0] i_cache_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  riscv_soft_fetch dut (
    .clk                (clk),
    .reset              (reset),
    .i_cache_req_ready  (i_cache_req_ready),
    .i_cache_req_valid  (i_cache_req_valid),
    .i_cache_req_addr   (i_cache_req_addr),
    .i_cache_resp_valid (i_cache_resp_valid),
    .i_cache_resp_data  (i_cache_resp_data),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .inst_valid         (inst_valid),
    .inst_ready         (inst_ready),
    .inst_data          (inst_data),
    .inst_pc            (inst_pc)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] addr; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; int cyc; } inst_t;

  pend_t pend[$];
  req_t  req_log[$];
  inst_t delivered[$];

  int          cyc = 0;
  int          lat = 1;
  bit          rand_ready = 1'b0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Cache model plus request/delivery monitor; drives just after the edge,
  // samples at the falling edge.
  initial begin
    i_cache_req_ready  = 1'b1;
    i_cache_resp_valid = 1'b0;
    i_cache_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        pend.delete();
        i_cache_req_ready  = 1'b1;
        i_cache_resp_valid = 1'b0;
        i_cache_resp_data  = 32'h0;
        prev_stall         = 1'b0;
      end else begin
        i_cache_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          i_cache_resp_valid = 1'b1;
          i_cache_resp_data  = word_at(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          i_cache_resp_valid = 1'b0;
          i_cache_resp_data  = 32'h0;
        end
      end
      @(negedge clk);
      if (!reset) begin
        if (prev_stall && i_cache_req_valid && i_cache_req_addr !== prev_addr) stab_err++;
        prev_stall = i_cache_req_valid && !i_cache_req_ready;
        prev_addr  = i_cache_req_addr;
        if (i_cache_req_valid && i_cache_req_ready) begin
          pend.push_back('{i_cache_req_addr, cyc + lat});
          req_log.push_back('{i_cache_req_addr, cyc});
        end
        if (inst_valid && inst_ready) delivered.push_back('{inst_pc, inst_data, cyc});
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    delivered.delete();
    req_log.delete();
    stab_err = 0;
  endtask

  task automatic release_reset(output int c0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    c0    = cyc;
  endtask

  initial begin
    int c0;
    int seq_err;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_valid", i_cache_req_valid, 0);
    check("rst_req_addr", i_cache_req_addr, 32'h200);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_inst_pc", inst_pc, 0);

    // Streaming, 1-cycle latency, consumer always ready
    lat = 1;
    inst_ready = 1'b1;
    release_reset(c0);
    @(negedge clk);
    check("t1_first_req_valid", i_cache_req_valid, 1);
    check("t1_first_req_addr", i_cache_req_addr, 32'h200);
    repeat (12) @(negedge clk);
    check("t1_enough_delivered", delivered.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      check("t1_req_addr", req_log[i].addr, 32'h200 + 4 * i);
      check("t1_req_cyc", req_log[i].cyc, c0 + i);
      check("t1_inst_pc", delivered[i].pc, 32'h200 + 4 * i);
      check("t1_inst_data", delivered[i].data, word_at(32'h200 + 4 * i));
      check("t1_inst_cyc", delivered[i].cyc, c0 + 2 + i);
    end

    // Consumer stalled: exactly DEPTH requests, then drain in order
    apply_reset();
    inst_ready = 1'b0;
    lat = 1;
    release_reset(c0);
    repeat (10) @(negedge clk);
    check("t2_req_count", req_log.size(), 4);
    check("t2_req_valid_low", i_cache_req_valid, 0);
    check("t2_inst_valid", inst_valid, 1);
    check("t2_head_pc", inst_pc, 32'h200);
    check("t2_head_data", inst_data, word_at(32'h200));
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t2_drain_pc", delivered[i].pc, 32'h200 + 4 * i);
    end
    check("t2_resume_addr", req_log[4].addr, 32'h210);

    // Random request stalls, 3-cycle latency, random consumer
    apply_reset();
    lat = 3;
    rand_ready = 1'b1;
    inst_ready = 1'b1;
    release_reset(c0);
    repeat (150) begin
      @(posedge clk);
      #1;
      inst_ready = 1'($urandom_range(0, 1));
    end
    rand_ready = 1'b0;
    inst_ready = 1'b0;
    repeat (20) @(negedge clk);
    seq_err = 0;
    foreach (delivered[i]) begin
      if (delivered[i].pc !== 32'h200 + 4 * i || delivered[i].data !== word_at(32'h200 + 4 * i)) seq_err++;
    end
    check("t3_sequence", seq_err, 0);
    check("t3_addr_stable", stab_err, 0);
    check("t3_progress", delivered.size() > 20, 1);
    check("t3_no_loss", delivered.size() + 4, req_log.size());
    check("t3_head_pc", inst_pc, 32'h200 + 4 * delivered.size());

    // Redirect with two requests in flight
    apply_reset();
    lat = 3;
    inst_ready = 1'b1;
    release_reset(c0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    @(negedge clk);
    check("t4_no_req_in_redirect", i_cache_req_valid, 0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_fifo_empty", inst_valid, 0);
    check("t4_drop_cnt", dut.drop_cnt, 2);
    check("t4_target_req_valid", i_cache_req_valid, 1);
    check("t4_target_req_addr", i_cache_req_addr, 32'h1000);
    repeat (10) @(negedge clk);
    check("t4_first_pc", delivered[0].pc, 32'h1000);
    check("t4_first_data", delivered[0].data, word_at(32'h1000));
    check("t4_first_cyc", delivered[0].cyc, c0 + 7);
    check("t4_second_pc", delivered[1].pc, 32'h1004);

    // Redirect coincident with a response and a dequeue
    apply_reset();
    lat = 2;
    inst_ready = 1'b1;
    release_reset(c0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    @(negedge clk);
    check("t5_resp_coincident", i_cache_resp_valid, 1);
    check("t5_deq_pc", inst_pc, 32'h204);
    check("t5_no_req", i_cache_req_valid, 0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_drop_cnt", dut.drop_cnt, 1);
    check("t5_fifo_empty", inst_valid, 0);
    repeat (8) @(negedge clk);
    check("t5_pc0", delivered[0].pc, 32'h200);
    check("t5_pc1", delivered[1].pc, 32'h204);
    check("t5_pc2", delivered[2].pc, 32'h2000);
    check("t5_data2", delivered[2].data, word_at(32'h2000));

    // Asynchronous reset mid-operation
    apply_reset();
    lat = 2;
    inst_ready = 1'b0;
    release_reset(c0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    check("t6_pre_inst_valid", inst_valid, 1);
    check("t6_pre_req_valid", i_cache_req_valid, 1);
    reset = 1'b1;
    #1;
    check("t6_async_inst_valid", inst_valid, 0);
    check("t6_async_req_valid", i_cache_req_valid, 0);
    check("t6_async_inst_pc", inst_pc, 0);
    repeat (2) @(posedge clk);
    delivered.delete();
    req_log.delete();
    inst_ready = 1'b1;
    release_reset(c0);
    @(negedge clk);
    check("t6_restart_valid", i_cache_req_valid, 1);
    check("t6_restart_addr", i_cache_req_addr, 32'h200);
    repeat (6) @(negedge clk);
    check("t6_restart_pc", delivered[0].pc, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
